// File: rtl/decoder_3_8_seq_if.sv
// Handshake and one-hot output bundle for decoder_3_8_seq.
// The master drives indices in and watches the decoded strobes; the slave is the decoder.
interface decoder_3_8_seq_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_idx;
   logic [7:0] out;
   logic       out_valid;
   logic       done;

   modport master (
      output in_valid, in_idx,
      input  in_ready, out, out_valid, done
   );

   modport slave (
      input  in_valid, in_idx,
      output in_ready, out, out_valid, done
   );
endinterface

// File: rtl/decoder_3_8_seq.sv
// Registered 3-to-8 one-hot decoder with a valid/ready input and HOLD-cycle strobes.
//
// state | meaning
// IDLE  | nothing driven, out = 0, ready for an index
// DRIVE | one-hot code on out; cnt counts the remaining cycles down to 0
module decoder_3_8_seq #(
   parameter int HOLD  = 4,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   input logic              clr,
   decoder_3_8_seq_if.slave bus
);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         out_q, out_d;
   logic               in_ready;
   logic               accept;

   // Ready on the last DRIVE cycle too, so consecutive codes follow with no bubble.
   assign in_ready = !rst && !clr && (state_q == IDLE || cnt_q == '0);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         out_d   = 8'h00;
      end else if (accept) begin
         state_d = DRIVE;
         cnt_d   = CNT_W'(HOLD - 1);
         out_d   = 8'b1 << bus.in_idx;
      end else if (state_q == DRIVE) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            state_d = IDLE;
            out_d   = 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out       = out_q;
   assign bus.out_valid = (state_q == DRIVE);
   assign bus.done      = (state_q == DRIVE) && (cnt_q == '0);

endmodule

// File: tb/tb_decoder_3_8_seq.sv
// Bench for decoder_3_8_seq: a HOLD=4 and a HOLD=1 instance share clk/rst/clr and are
// compared every cycle against a remaining-cycles model, plus literal directed checks.
module tb_decoder_3_8_seq;

   localparam int HOLDS [2] = '{4, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       vin  [2];
   logic [2:0] vidx [2];

   int n_total = 0;
   int n_pass  = 0;

   decoder_3_8_seq_if bus4 ();
   decoder_3_8_seq_if bus1 ();

   assign bus4.in_valid = vin[0];
   assign bus4.in_idx   = vidx[0];
   assign bus1.in_valid = vin[1];
   assign bus1.in_idx   = vidx[1];

   decoder_3_8_seq #(.HOLD(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .clr(clr), .bus(bus4));
   decoder_3_8_seq #(.HOLD(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .clr(clr), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      else
         n_pass++;
   endtask

   // Model: each instance remembers the index being shown and how many cycles it has left.
   int rem  [2] = '{0, 0};
   int code [2] = '{0, 0};
   bit acc  [2] = '{0, 0};
   bit model_live = 0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         acc[k] = vin[k] && !rst && !clr && (rem[k] <= 1);
         if (rst || clr) begin
            rem[k]  = 0;
            code[k] = 0;
         end else if (acc[k]) begin
            rem[k]  = HOLDS[k];
            code[k] = int'(vidx[k]);
         end else if (rem[k] > 0) begin
            rem[k]--;
         end
      end
      if (rst) model_live = 1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         for (int k = 0; k < 2; k++) begin
            logic [7:0] e_out;
            logic [7:0] g_out;
            logic       g_val, g_done, g_rdy;
            e_out = (rem[k] > 0) ? (8'b1 << code[k]) : 8'h00;
            if (k == 0) begin
               g_out = bus4.out; g_val = bus4.out_valid; g_done = bus4.done; g_rdy = bus4.in_ready;
            end else begin
               g_out = bus1.out; g_val = bus1.out_valid; g_done = bus1.done; g_rdy = bus1.in_ready;
            end
            chk($sformatf("model_out[h%0d]", HOLDS[k]), g_out, e_out);
            chk($sformatf("model_valid[h%0d]", HOLDS[k]), {7'd0, g_val}, {7'd0, rem[k] > 0});
            chk($sformatf("model_done[h%0d]", HOLDS[k]), {7'd0, g_done}, {7'd0, rem[k] == 1});
            chk($sformatf("model_ready[h%0d]", HOLDS[k]), {7'd0, g_rdy},
                {7'd0, !rst && !clr && (rem[k] <= 1)});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] b2b_exp [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
   logic [2:0] b2b_idx [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
   logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      int i;
      vin[0] = 0; vin[1] = 0; vidx[0] = 0; vidx[1] = 0;

      // reset
      step();
      @(negedge clk);
      chk("rst_ready", {7'd0, bus4.in_ready}, 8'd0);
      chk("rst_out", bus4.out, 8'h00);
      step();
      rst = 0;
      @(negedge clk);
      chk("idle_out", bus4.out, 8'h00);
      chk("idle_valid", {7'd0, bus4.out_valid}, 8'd0);
      chk("idle_done", {7'd0, bus4.done}, 8'd0);
      chk("idle_ready", {7'd0, bus4.in_ready}, 8'd1);

      // single index 5
      vin[0] = 1; vidx[0] = 3'd5;
      step();
      vin[0] = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("single_out", bus4.out, 8'h20);
         chk("single_done", {7'd0, bus4.done}, {7'd0, c == 4});
         step();
      end
      @(negedge clk);
      chk("single_after", bus4.out, 8'h00);

      // back-to-back 0,1,2,7
      step();
      i = 0; vin[0] = 1; vidx[0] = b2b_idx[0];
      for (int cyc = 0; cyc < 17; cyc++) begin
         step();
         if (acc[0]) begin
            i++;
            if (i < 4) vidx[0] = b2b_idx[i];
            else vin[0] = 0;
         end
         @(negedge clk);
         if (cyc < 16) begin
            chk("b2b_out", bus4.out, b2b_exp[cyc / 4]);
            chk("b2b_ready", {7'd0, bus4.in_ready}, {7'd0, (cyc % 4) == 3});
         end else begin
            chk("b2b_end", bus4.out, 8'h00);
            chk("b2b_end_ready", {7'd0, bus4.in_ready}, 8'd1);
         end
      end

      // HOLD=1 sweep
      vin[1] = 1; vidx[1] = 3'd0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k < 7) vidx[1] = 3'(k + 1);
         else vin[1] = 0;
         @(negedge clk);
         chk("sweep_out", bus1.out, sweep_exp[k]);
         chk("sweep_done", {7'd0, bus1.done}, 8'd1);
      end
      step();

      // abort with clr while idx 6 waits
      vin[0] = 1; vidx[0] = 3'd3;
      step();
      vidx[0] = 3'd6;
      @(negedge clk);
      chk("abort_out1", bus4.out, 8'h08);
      step();
      clr = 1;
      @(negedge clk);
      chk("abort_out2", bus4.out, 8'h08);
      chk("abort_ready", {7'd0, bus4.in_ready}, 8'd0);
      step();
      clr = 0;
      chk("abort_noacc", {7'd0, acc[0]}, 8'd0);
      @(negedge clk);
      chk("abort_cleared", bus4.out, 8'h00);
      chk("abort_ready2", {7'd0, bus4.in_ready}, 8'd1);
      step();
      chk("abort_acc", {7'd0, acc[0]}, 8'd1);
      vin[0] = 0;
      @(negedge clk);
      chk("abort_next", bus4.out, 8'h40);
      for (int c = 0; c < 4; c++) step();

      // reset mid-drive with backpressure
      vin[0] = 1; vidx[0] = 3'd7;
      step();
      vidx[0] = 3'd2;
      @(negedge clk);
      chk("bp_out", bus4.out, 8'h80);
      chk("bp_ready", {7'd0, bus4.in_ready}, 8'd0);
      step();
      chk("bp_held", {7'd0, acc[0]}, 8'd0);
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      chk("rstmid_out", bus4.out, 8'h00);
      chk("rstmid_valid", {7'd0, bus4.out_valid}, 8'd0);
      step();
      chk("rstmid_acc", {7'd0, acc[0]}, 8'd1);
      vin[0] = 0;
      @(negedge clk);
      chk("rstmid_next", bus4.out, 8'h04);
      for (int c = 0; c < 4; c++) step();

      // randomized traffic on both instances, obeying the hold-until-accepted rule
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (!(vin[k] && !acc[k])) begin
               vin[k]  = ($urandom_range(0, 3) != 0);
               vidx[k] = 3'($urandom_range(0, 7));
            end
         end
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 99) == 0);
      end
      step();
      rst = 0; clr = 0; vin[0] = 0; vin[1] = 0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
